// File: rtl/stb_gen_ctrl.sv
// stb_gen_ctrl: sequences stb_gen through reset, detection window, lock wait and a
// counted strobe run, reporting completion status and the period measured at lock.
module stb_gen_ctrl #(
  parameter int T_CNT_WIDTH   = 32,
  parameter int RST_CYCLES    = 4,
  parameter int DET_CYCLES    = 48,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int NSTB_WIDTH    = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  input  logic [NSTB_WIDTH-1:0]    nstb_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               status_o,
  output logic [T_CNT_WIDTH-1:0]   period_o,
  output logic [NSTB_WIDTH-1:0]    stb_cnt_o,
  output logic                     gen_arst_o,
  output logic                     gen_run_det_o,
  output logic                     gen_oe_o,
  input  logic                     gen_stb_i,
  input  logic                     gen_err_i,
  input  logic                     gen_rdy_i,
  input  logic [T_CNT_WIDTH-1:0]   gen_period_i
);
  typedef enum logic [2:0] {IDLE, RESET, DETECT, WAIT_RDY, RUN, DONE} state_t;
  localparam int PH_MAX = RST_CYCLES > DET_CYCLES ? RST_CYCLES : DET_CYCLES;
  localparam int PW = $clog2(PH_MAX + 1);
  localparam logic [1:0] ST_OK = 2'd0, ST_ERR = 2'd1, ST_TMO = 2'd2, ST_ABORT = 2'd3;
  state_t state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [TIMEOUT_WIDTH-1:0] to_q, to_d, tmo_q, tmo_d;
  logic [NSTB_WIDTH-1:0] nstb_q, nstb_d, cnt_q, cnt_d;
  logic [1:0] status_q, status_d;
  logic [T_CNT_WIDTH-1:0] period_q, period_d;
  logic stb_q, rise, busy_q, done_q, arst_q, det_q, oe_q;
  assign rise = gen_stb_i & ~stb_q;
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    to_d     = to_q;
    tmo_d    = tmo_q;
    nstb_d   = nstb_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    period_d = period_q;
    case (state_q)
      IDLE: begin
        ph_d = '0;
        to_d = '0;
        if (start_i) begin
          state_d = RESET;
          cnt_d   = '0;
          nstb_d  = nstb_i;
          tmo_d   = timeout_i;
        end
      end
      RESET, DETECT: begin
        if (abort_i) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (ph_q == PW'((state_q == RESET ? RST_CYCLES : DET_CYCLES) - 1)) begin
          state_d = state_q == RESET ? DETECT : WAIT_RDY;
          ph_d    = '0;
        end else ph_d = ph_q + PW'(1);
      end
      WAIT_RDY: begin
        to_d = to_q + TIMEOUT_WIDTH'(1);
        if (abort_i) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (gen_err_i) begin
          state_d  = DONE;
          status_d = ST_ERR;
        end else if (gen_rdy_i) begin
          state_d  = RUN;
          period_d = gen_period_i;
        end else if (tmo_q != '0 && to_q == tmo_q - TIMEOUT_WIDTH'(1)) begin
          state_d  = DONE;
          status_d = ST_TMO;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (gen_err_i) begin
          state_d  = DONE;
          status_d = ST_ERR;
        end else if (rise && cnt_q != '1) begin
          cnt_d = cnt_q + NSTB_WIDTH'(1);
          if (nstb_q != '0 && cnt_d == nstb_q) begin
            state_d  = DONE;
            status_d = ST_OK;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Generator controls are decoded from the next state so every output is a flop.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      to_q     <= '0;
      tmo_q    <= '0;
      nstb_q   <= '0;
      cnt_q    <= '0;
      status_q <= ST_OK;
      period_q <= '0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      arst_q   <= 1'b1;
      det_q    <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      to_q     <= to_d;
      tmo_q    <= tmo_d;
      nstb_q   <= nstb_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      period_q <= period_d;
      stb_q    <= gen_stb_i;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
      arst_q   <= state_d == RESET;
      det_q    <= state_d == DETECT;
      oe_q     <= state_d == RUN;
    end
  end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign status_o      = status_q;
  assign period_o      = period_q;
  assign stb_cnt_o     = cnt_q;
  assign gen_arst_o    = arst_q;
  assign gen_run_det_o = det_q;
  assign gen_oe_o      = oe_q;
endmodule
